fa_align_stage: RTL and testbench
=================================

Name: fa_align_stage

Overview:
- Parametrised first stage of the floating-point add/subtract pipeline.
- Unpacks two IEEE-style operands and applies an add/sub opcode.
- Orders the operands by magnitude, aligns the smaller significand with guard/round/sticky bits, and resolves NaN/Inf/zero special cases.
- Registers the result behind a valid/ready elastic buffer (2-entry skid) that feeds the adder stage.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width. Derived: W = 1+EXP_W+MAN_W; SIG_W = MAN_W+4 (hidden + fraction + G,R,S).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept.
- A  in  W  operand A.
- B  in  W  operand B.
- sub  in  1  1 = A-B, 0 = A+B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_sign  out  1  result sign.
- out_exp  out  EXP_W  common (larger) exponent.
- out_big  out  SIG_W  larger-magnitude significand, GRS = 0.
- out_small  out  SIG_W  aligned smaller significand incl. GRS.
- out_eff_sub  out  1  1 = magnitudes are subtracted.
- out_special  out  1  result fixed; out_special_val is final.
- out_special_val  out  W  NaN/Inf result.

Behaviour:
- Reset: async clear of both buffer entries. out_valid=0, all out_* data=0, in_ready=1.
- Effective B sign: sB' = B[W-1]^sub. out_eff_sub = sA^sB'.
- Hidden bit = 1 when exp!=0. Exp==0 means zero: sig=0, fraction ignored.
- Swap: compare {exp,frac} as unsigned magnitude. Big = larger; on tie, A is big. diff = exp_big-exp_small.
- Shift: small_sig (hidden,frac,000) is shifted right by diff. Sticky (LSB) = OR of all bits shifted out, OR'd into the LSB. If diff >= SIG_W: small = {0..0,|small_sig}.
- Sign:
  - Normal case: out_sign = sign of big.
  - Equal magnitudes with eff_sub: sign 0.
  - Both zero: sign = sA & sB'.
- Specials, checked first:
  - Any NaN, or Inf with Inf and eff_sub: out_special=1, val = canonical qNaN {0, all-ones, 1, 0..0}.
  - Otherwise any Inf: val = Inf with that operand's effective sign.
  - Non-special: out_special=0, val=0.
- Handshake:
  - Transfer occurs when valid&&ready on the same edge. out_valid/out data are stable while out_valid&&!out_ready.
  - Latency is 1 cycle (accept at edge N gives out_valid after edge N). Throughput is 1 per cycle.
- Buffer FSM:
  - States: EMPTY, ONE, TWO. in_ready = (state!=TWO), registered.
  - EMPTY: in accept goes to ONE.
  - ONE: in only goes to TWO. Out only goes to EMPTY. Simultaneous in and out stays in ONE, and the main register loads new data.
  - TWO: out accept goes to ONE; the skid entry moves into the main register. No input is accepted in TWO.
  - Ordering is strictly FIFO; no drop, no duplication.
- RESET mid-operation discards both entries immediately; out_valid falls asynchronously.

Optional Feature:
- Macro: FA_DENORM_EN.
- Defined: exp==0 with frac!=0 is subnormal. Hidden bit 0, effective exponent 1 for diff and out_exp; out_exp = 1 when both operands are subnormal/zero and any frac!=0.
- Undefined: subnormals flush to zero, with the sign kept.

Decomposition:
- Package fa_pkg:
  - EXP_W/MAN_W defaults.
  - Buffer-state enum typedef.
  - Payload struct (sign, exp, big, small, eff_sub, special, special_val).
  - qNaN/Inf constant functions of EXP_W/MAN_W.
- Sub-module fa_align_shift: parametrised right shifter with sticky generation and saturation at diff >= SIG_W.

Test Plan:
- A=3F800000, B=3F800000, sub=0 -> out_exp=7F, big=small=27'h4000000, eff_sub=0, sign=0, special=0.
- A=3F800000, B=3F800000, sub=1 -> eff_sub=1, sign=0, big=small=27'h4000000.
- A=3F800000, B=30800000 (diff 30) -> out_exp=7F, small=27'h0000001 (sticky only).
- A=7F800000, B=7F800000, sub=1 -> special=1, val=7FC00000. A=7F800000, B=3F800000 -> val=7F800000.
- Three back-to-back inputs with out_ready=0:
  - Two are accepted; in_ready=0 after the 2nd accept; out holds the 1st unchanged.
  - Raise out_ready -> outputs appear 1,2,3 in order, one per cycle.
- Assert RESET in state TWO -> out_valid=0 without a clock edge, in_ready=1. Release -> a fresh transaction passes after 1 cycle.
- (FA_DENORM_EN) A=00000001, B=00000001 -> out_exp=1, big=small=27'h0000008. Without the macro -> both zero, out_exp=0.

Source files
------------

// File: rtl/fa_pkg.sv
// rtl/fa_pkg.sv - shared types and constants for the fp add/sub align stage
//
// Purpose : default field widths, skid-buffer state encoding, the default-width
//           payload record, and canonical qNaN / Inf constant builders.
// Ports   : none (package).
package fa_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int DEF_W     = 1 + DEF_EXP_W + DEF_MAN_W;
    localparam int DEF_SIG_W = DEF_MAN_W + 4;

    // Widest encoding the constant builders can produce.
    localparam int FP_MAX_W = 64;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic                 sign;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_SIG_W-1:0] sig_big;
        logic [DEF_SIG_W-1:0] sig_small;
        logic                 eff_sub;
        logic                 special;
        logic [DEF_W-1:0]     special_val;
    } payload_t;

    // {0, all-ones exponent, quiet bit, zeros}, right-aligned in FP_MAX_W bits.
    function automatic logic [FP_MAX_W-1:0] fa_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w+i] = 1'b1;
        end
        v[man_w-1] = 1'b1;
        return v;
    endfunction

    // {sign, all-ones exponent, zero fraction}, right-aligned in FP_MAX_W bits.
    function automatic logic [FP_MAX_W-1:0] fa_inf(input logic sign, input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w+i] = 1'b1;
        end
        v[exp_w+man_w] = sign;
        return v;
    endfunction

endpackage

// File: rtl/fa_align_stage_if.sv
// rtl/fa_align_stage_if.sv - operand-in / aligned-result-out handshake bundle
//
// Purpose : groups the upstream operand handshake and the downstream aligned
//           payload handshake of fa_align_stage.
// Modports: master - upstream/downstream environment (drives operands, out_ready)
//           slave  - the align stage (drives in_ready and all out_* signals)
interface fa_align_stage_if
    import fa_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) ();
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 4;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [EXP_W-1:0] out_exp;
    logic [SIG_W-1:0] out_big;
    logic [SIG_W-1:0] out_small;
    logic             out_eff_sub;
    logic             out_special;
    logic [W-1:0]     out_special_val;

    modport master (
        output in_valid, A, B, sub, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_big, out_small,
               out_eff_sub, out_special, out_special_val
    );

    modport slave (
        input  in_valid, A, B, sub, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_big, out_small,
               out_eff_sub, out_special, out_special_val
    );
endinterface

// File: rtl/fa_align_shift.sv
// rtl/fa_align_shift.sv - sticky-preserving right shifter for significand alignment
//
// Purpose : shifts sig_i right by diff_i; every bit shifted out is OR'd into the
//           result LSB. Shift amounts of SIG_W or more collapse to {0..0, |sig_i}.
// Ports   : sig_i  [SIG_W] significand {hidden, frac, G, R, S}
//           diff_i [SH_W]  exponent difference
//           sig_o  [SIG_W] aligned significand with sticky
module fa_align_shift #(
    parameter int SIG_W = 27,
    parameter int SH_W  = 8
) (
    input  logic [SIG_W-1:0] sig_i,
    input  logic [SH_W-1:0]  diff_i,
    output logic [SIG_W-1:0] sig_o
);
    logic [SIG_W-1:0] shifted;
    logic [SIG_W-1:0] lost_mask;
    logic             sat;

    always_comb begin
        sat       = 32'(diff_i) >= 32'(SIG_W);
        shifted   = sig_i >> diff_i;
        // Ones in exactly the positions that fall off the right end.
        lost_mask = ~({SIG_W{1'b1}} << diff_i);
        if (sat) begin
            sig_o = {{(SIG_W-1){1'b0}}, |sig_i};
        end else begin
            sig_o = shifted | {{(SIG_W-1){1'b0}}, |(sig_i & lost_mask)};
        end
    end
endmodule

// File: rtl/fa_align_stage.sv
// rtl/fa_align_stage.sv - fp add/sub stage 1: unpack, order, align, specials, skid buffer
//
// Purpose : applies the add/sub opcode, orders operands by magnitude, aligns the
//           smaller significand (G/R/S), resolves NaN/Inf, and registers the
//           payload in a 2-entry skid buffer with registered in_ready.
// Ports   : CLK   - rising-edge clock
//           RESET - asynchronous active-high reset
//           bus   - fa_align_stage_if.slave (operands in, aligned payload out)
// Config  : FA_DENORM_EN - when defined, exp==0 with frac!=0 is a subnormal
//           (hidden 0, effective exponent 1); otherwise it flushes to signed zero.
module fa_align_stage
    import fa_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic            CLK,
    input  logic            RESET,
    fa_align_stage_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 4;

    localparam logic [W-1:0]     QNAN     = W'(fa_qnan(EXP_W, MAN_W));
    localparam logic [W-1:0]     INF      = W'(fa_inf(1'b0, EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig_big;
        logic [SIG_W-1:0] sig_small;
        logic             eff_sub;
        logic             special;
        logic [W-1:0]     special_val;
    } stage_t;

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, xa, xb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic             a_big, mag_eq, eff_sub;
    logic [SIG_W-1:0] a_sig, b_sig, big_sig, small_sig, small_al;
    logic [EXP_W-1:0] big_x, small_x, diff;
    stage_t           res;

    assign sa = bus.A[W-1];
    assign sb = bus.B[W-1] ^ bus.sub;
    assign ea = bus.A[W-2:MAN_W];
    assign eb = bus.B[W-2:MAN_W];
    assign fa = bus.A[MAN_W-1:0];
    assign fb = bus.B[MAN_W-1:0];

    // Unpack and order operands by magnitude.
    always_comb begin
        a_nan = (ea == EXP_ONES) && (fa != '0);
        b_nan = (eb == EXP_ONES) && (fb != '0);
        a_inf = (ea == EXP_ONES) && (fa == '0);
        b_inf = (eb == EXP_ONES) && (fb == '0);
`ifdef FA_DENORM_EN
        a_zero = (ea == '0) && (fa == '0);
        b_zero = (eb == '0) && (fb == '0);
        xa     = (ea != '0) ? ea : EXP_W'(fa != '0);
        xb     = (eb != '0) ? eb : EXP_W'(fb != '0);
        a_sig  = {ea != '0, fa, 3'b000};
        b_sig  = {eb != '0, fb, 3'b000};
`else
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        xa     = ea;
        xb     = eb;
        a_sig  = a_zero ? '0 : {1'b1, fa, 3'b000};
        b_sig  = b_zero ? '0 : {1'b1, fb, 3'b000};
`endif
        // Fraction taken from the (possibly flushed) significand so a flushed
        // subnormal compares equal to zero.
        a_big     = {ea, a_sig[SIG_W-2:3]} >= {eb, b_sig[SIG_W-2:3]};
        mag_eq    = {ea, a_sig[SIG_W-2:3]} == {eb, b_sig[SIG_W-2:3]};
        eff_sub   = sa ^ sb;
        big_x     = a_big ? xa : xb;
        small_x   = a_big ? xb : xa;
        big_sig   = a_big ? a_sig : b_sig;
        small_sig = a_big ? b_sig : a_sig;
        diff      = big_x - small_x;
    end

    fa_align_shift #(
        .SIG_W (SIG_W),
        .SH_W  (EXP_W)
    ) u_shift (
        .sig_i  (small_sig),
        .diff_i (diff),
        .sig_o  (small_al)
    );

    // Result payload assembly.
    always_comb begin
        res           = '0;
        res.eff_sub   = eff_sub;
        res.exp       = big_x;
        res.sig_big   = big_sig;
        res.sig_small = small_al;
        if (a_zero && b_zero) begin
            res.sign = sa & sb;
        end else if (mag_eq && eff_sub) begin
            res.sign = 1'b0;
        end else begin
            res.sign = a_big ? sa : sb;
        end
        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            res.special     = 1'b1;
            res.special_val = QNAN;
        end else if (a_inf) begin
            res.special     = 1'b1;
            res.special_val = {sa, INF[W-2:0]};
        end else if (b_inf) begin
            res.special     = 1'b1;
            res.special_val = {sb, INF[W-2:0]};
        end
    end

    // Two-entry skid buffer: main_q is what the output shows, skid_q catches
    // the one extra beat accepted while in_ready was still high.
    buf_state_e state_q, state_d;
    stage_t     main_q, main_d, skid_q, skid_d;
    logic       in_ready_q, in_ready_d;
    logic       in_fire, out_fire;

    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = (state_q != BUF_EMPTY) && bus.out_ready;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= BUF_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (in_fire) begin
                    main_d  = res;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = res;
                end else if (in_fire) begin
                    skid_d  = res;
                    state_d = BUF_TWO;
                end else if (out_fire) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        in_ready_d = (state_d != BUF_TWO);
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = (state_q != BUF_EMPTY);
    assign bus.out_sign        = main_q.sign;
    assign bus.out_exp         = main_q.exp;
    assign bus.out_big         = main_q.sig_big;
    assign bus.out_small       = main_q.sig_small;
    assign bus.out_eff_sub     = main_q.eff_sub;
    assign bus.out_special     = main_q.special;
    assign bus.out_special_val = main_q.special_val;
endmodule

// File: tb/tb_fa_align_stage.sv
// tb/tb_fa_align_stage.sv - scoreboard bench for fa_align_stage
module tb_fa_align_stage;
    import fa_pkg::*;

    localparam int EW = DEF_EXP_W;
    localparam int MW = DEF_MAN_W;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    fa_align_stage_if #(.EXP_W(EW), .MAN_W(MW)) bus ();

    fa_align_stage #(.EXP_W(EW), .MAN_W(MW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int       tests = 0;
    int       fails = 0;
    payload_t sb_q[$];
    bit       prev_stall = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: real-number style decode, ordering by magnitude, alignment by
    // integer division by 2**diff with remainder as sticky.
    function automatic payload_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        payload_t p;
        logic     sa, sbx;
        int       ea, eb, xa, xb, diff;
        longint   fa, fb, ma, mb, ka, kb, sm, pw, q, r;
        bit       za, zb, na, nb, ia, ib, abig;
        sa  = a[31];
        sbx = b[31] ^ s;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        fa  = longint'(a[22:0]);
        fb  = longint'(b[22:0]);
        na  = (ea == 255) && (fa != 0);
        nb  = (eb == 255) && (fb != 0);
        ia  = (ea == 255) && (fa == 0);
        ib  = (eb == 255) && (fb == 0);
`ifdef FA_DENORM_EN
        za = (ea == 0) && (fa == 0);
        zb = (eb == 0) && (fb == 0);
        ma = (ea == 0) ? fa : fa + 8388608;
        mb = (eb == 0) ? fb : fb + 8388608;
        xa = (ea == 0) ? ((fa != 0) ? 1 : 0) : ea;
        xb = (eb == 0) ? ((fb != 0) ? 1 : 0) : eb;
`else
        za = (ea == 0);
        zb = (eb == 0);
        ma = za ? 0 : fa + 8388608;
        mb = zb ? 0 : fb + 8388608;
        xa = ea;
        xb = eb;
`endif
        ka   = za ? 0 : longint'(ea) * 8388608 + fa;
        kb   = zb ? 0 : longint'(eb) * 8388608 + fb;
        abig = ka >= kb;
        p           = '0;
        p.eff_sub   = sa ^ sbx;
        p.exp       = 8'(abig ? xa : xb);
        diff        = abig ? xa - xb : xb - xa;
        p.sig_big   = 27'((abig ? ma : mb) * 8);
        sm          = (abig ? mb : ma) * 8;
        if (diff >= 27) begin
            p.sig_small = 27'(sm != 0);
        end else begin
            pw = longint'(2) ** diff;
            q  = sm / pw;
            r  = sm % pw;
            p.sig_small = 27'(q) | 27'(r != 0);
        end
        if (za && zb)                 p.sign = sa & sbx;
        else if (ka == kb && p.eff_sub) p.sign = 1'b0;
        else                          p.sign = abig ? sa : sbx;
        if (na || nb || (ia && ib && p.eff_sub)) begin
            p.special = 1'b1; p.special_val = 32'h7FC00000;
        end else if (ia) begin
            p.special = 1'b1; p.special_val = {sa, 8'hFF, 23'h0};
        end else if (ib) begin
            p.special = 1'b1; p.special_val = {sbx, 8'hFF, 23'h0};
        end
        return p;
    endfunction

    function automatic bit same(input payload_t e);
        if (bus.out_special !== e.special || bus.out_special_val !== e.special_val ||
            bus.out_eff_sub !== e.eff_sub) return 1'b0;
        if (e.special) return 1'b1;
        return (bus.out_sign === e.sign) && (bus.out_exp === e.exp) &&
               (bus.out_big === e.sig_big) && (bus.out_small === e.sig_small);
    endfunction

    // Monitor: pops on every output transfer, checks hold during stalls, and
    // records every accepted input into the scoreboard.
    initial begin : monitor
        payload_t e;
        logic [98:0] cur, prev_snap;
        prev_snap = '0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                prev_stall = 0;
            end else begin
                cur = {bus.out_sign, bus.out_exp, bus.out_big, bus.out_small,
                       bus.out_eff_sub, bus.out_special, bus.out_special_val};
                if (prev_stall) begin
                    tests++;
                    if (!bus.out_valid || cur !== prev_snap) begin
                        fails++;
                        $display("FAIL hold: got valid=%0b data=%0h expected valid=1 data=%0h",
                                 bus.out_valid, cur, prev_snap);
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    tests++;
                    if (sb_q.size() == 0) begin
                        fails++;
                        $display("FAIL sb_empty: got unexpected output exp=%0h expected none", bus.out_exp);
                    end else begin
                        e = sb_q.pop_front();
                        if (!same(e)) begin
                            fails++;
                            $display("FAIL sb_data: got s=%0b e=%0h big=%0h sm=%0h es=%0b sp=%0b v=%0h expected s=%0b e=%0h big=%0h sm=%0h es=%0b sp=%0b v=%0h",
                                     bus.out_sign, bus.out_exp, bus.out_big, bus.out_small, bus.out_eff_sub,
                                     bus.out_special, bus.out_special_val, e.sign, e.exp, e.sig_big,
                                     e.sig_small, e.eff_sub, e.special, e.special_val);
                        end
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_snap  = cur;
                if (bus.in_valid && bus.in_ready) sb_q.push_back(model(bus.A, bus.B, bus.sub));
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic s);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus.A = a; bus.B = b; bus.sub = s; bus.in_valid = 1'b1;
        while (!acc && n < 20) begin
            @(negedge CLK);
            acc = bus.in_ready;
            n++;
            @(posedge CLK);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("push_accept", acc, 1);
    endtask

    task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                            input logic norm, input logic [7:0] x_exp, input logic [26:0] x_big,
                            input logic [26:0] x_small, input logic x_eff, input logic x_sign,
                            input logic x_spec, input logic [31:0] x_val);
        push(a, b, s);
        @(negedge CLK);
        chk({nm, "_valid"}, bus.out_valid, 1);
        chk({nm, "_special"}, bus.out_special, x_spec);
        chk({nm, "_val"}, bus.out_special_val, x_val);
        if (norm) begin
            chk({nm, "_exp"}, bus.out_exp, x_exp);
            chk({nm, "_big"}, bus.out_big, x_big);
            chk({nm, "_small"}, bus.out_small, x_small);
            chk({nm, "_effsub"}, bus.out_eff_sub, x_eff);
            chk({nm, "_sign"}, bus.out_sign, x_sign);
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rand_op(input logic [31:0] other);
        logic [7:0]  e;
        logic [22:0] f;
        int unsigned sel;
        e   = 8'($urandom);
        f   = 23'($urandom);
        sel = $urandom % 10;
        case (sel)
            0: e = 8'h00;
            1: e = 8'hFF;
            2: e = other[30:23] + 8'($urandom % 4);
            3: e = other[30:23] - 8'($urandom % 30);
            4: begin e = 8'hFF; f = '0; end
            5: f = '0;
            6: return {~other[31], other[30:0]};
            default: ;
        endcase
        return {1'($urandom), e, f};
    endfunction

    initial begin : stim
        logic [31:0] a, b;
        logic        acc;
        int          n;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.sub = 1'b0;
        #2 RESET = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_exp", bus.out_exp, 0);
        chk("rst_out_big", bus.out_big, 0);
        chk("rst_special_val", bus.out_special_val, 0);
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        bus.out_ready = 1'b1;

        directed("add_eq", 32'h3F800000, 32'h3F800000, 1'b0, 1, 8'h7F, 27'h4000000, 27'h4000000, 0, 0, 0, 0);
        directed("sub_eq", 32'h3F800000, 32'h3F800000, 1'b1, 1, 8'h7F, 27'h4000000, 27'h4000000, 1, 0, 0, 0);
        directed("diff30", 32'h3F800000, 32'h30800000, 1'b0, 1, 8'h7F, 27'h4000000, 27'h0000001, 0, 0, 0, 0);
        directed("inf_inf", 32'h7F800000, 32'h7F800000, 1'b1, 0, 0, 0, 0, 1, 0, 1, 32'h7FC00000);
        directed("inf_one", 32'h7F800000, 32'h3F800000, 1'b0, 0, 0, 0, 0, 0, 0, 1, 32'h7F800000);
`ifdef FA_DENORM_EN
        directed("denorm", 32'h00000001, 32'h00000001, 1'b0, 1, 8'h01, 27'h0000008, 27'h0000008, 0, 0, 0, 0);
`else
        directed("flush", 32'h00000001, 32'h00000001, 1'b0, 1, 8'h00, 27'h0, 27'h0, 0, 0, 0, 0);
`endif

        // Back-pressure: two accepted, third stalls, then drain in order.
        bus.out_ready = 1'b0;
        push(32'h40400000, 32'h3F000000, 1'b0);
        push(32'hC1200000, 32'h3F800000, 1'b0);
        @(negedge CLK);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_hold_exp", bus.out_exp, 8'h80);
        chk("bp_hold_big", bus.out_big, 27'h6000000);
        chk("bp_hold_small", bus.out_small, 27'h1000000);
        fork
            begin
                #1;
                push(32'h00000000, 32'h80000000, 1'b1);
            end
            begin
                @(posedge CLK);
                #1 bus.out_ready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge CLK);
                    chk("bp_drain_valid", bus.out_valid, 1);
                end
            end
        join
        @(posedge CLK);
        #1;

        // Reset while full.
        bus.out_ready = 1'b0;
        push(32'h40400000, 32'h3F000000, 1'b0);
        push(32'h3F800000, 32'hBF800000, 1'b1);
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        sb_q.delete();
        prev_stall = 0;
        @(negedge CLK);
        #2 RESET = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge CLK);
        #1;
        push(32'h3F800000, 32'h40000000, 1'b0);
        @(negedge CLK);
        chk("post_rst_valid", bus.out_valid, 1);
        chk("post_rst_exp", bus.out_exp, 8'h80);
        chk("post_rst_small", bus.out_small, 27'h2000000);
        @(posedge CLK);
        #1;

        // Randomised traffic with random back-pressure.
        a = 32'h3F800000;
        for (int i = 0; i < 800; i++) begin
            @(negedge CLK);
            acc = bus.in_valid && bus.in_ready;
            @(posedge CLK);
            #1;
            bus.out_ready = ($urandom % 4) != 0;
            if (!bus.in_valid || acc) begin
                b = rand_op(a);
                a = rand_op(b);
                bus.A = a; bus.B = b; bus.sub = 1'($urandom);
                bus.in_valid = ($urandom % 4) != 0;
            end
        end
        @(negedge CLK);
        @(posedge CLK);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge CLK);
            n++;
        end
        @(negedge CLK);
        chk("drain_empty", sb_q.size(), 0);
        chk("drain_out_valid", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
